cv32e40p_instr_realigner: RTL and testbench
===========================================

// Module: cv32e40p_instr_realigner
// PURPOSE
//  Downstream neighbour of the prefetch buffer: consumes 32-bit word-aligned fetch words
//  (fetch_valid/fetch_ready) and emits one RV32IC instruction per handshake to the IF/ID stage.
//  Handles 16-bit compressed instructions, 32-bit instructions straddling a word boundary, and
//  branch targets on halfword (addr[1]=1) boundaries. Tracks the PC of the emitted instruction.
// PARAMETERS
//  COMPRESSED  1  1: RV32C realignment enabled; 0: every word is one 32-bit instr, addr[1] ignored
// PORTS
//  clk                 in   1   clock
//  rst_n               in   1   asynchronous active-low reset
//  branch_i            in   1   redirect; same cycle as prefetch branch_i
//  branch_addr_i       in   32  redirect target, bit0 == 0
//  fetch_valid_i       in   1   prefetch word valid
//  fetch_rdata_i       in   32  prefetch word (little-endian halfwords)
//  fetch_ready_o       out  1   pop word from prefetch buffer
//  instr_valid_o       out  1   aligned instruction valid
//  instr_rdata_o       out  32  instruction; compressed -> {16'h0, hword}
//  instr_compressed_o  out  1   instr_rdata_o[1:0] != 2'b11
//  pc_o                out  32  address of instr_rdata_o
//  id_ready_i          in   1   consumer accepts instruction
// BEHAVIOUR
//  - Async reset: state=IDLE, pc=0, hold=16'h0; all outputs 0 (pc_o=0).
//  - Regs: state, pc[31:0], hold[15:0] (upper halfword of last popped word). Combinational outputs.
//  - Word is 32-bit iff low halfword [1:0]==2'b11. Handshake: transfer on instr_valid_o && id_ready_i.
//  - fetch_ready_o never asserted without a transfer or a BR_HALF discard; never in a branch cycle.
//  - branch_i has absolute priority: instr_valid_o=0, fetch_ready_o=0; next pc=branch_addr_i,
//    state = (COMPRESSED && branch_addr_i[1]) ? BR_HALF : ALIGNED. Valid in any state incl. IDLE.
//  - States:
//    IDLE     : valid=0, ready=0; leaves only on branch_i.
//    ALIGNED  : valid=fetch_valid_i. 32-bit: instr=w; xfer -> pop, pc+=4, stay.
//               16-bit: instr={16'h0,w[15:0]}; xfer -> pop, hold<=w[31:16], pc+=2, -> HALF.
//    HALF     : hold[1:0]!=11: valid=1 (no fetch needed), instr={16'h0,hold}, ready=0;
//               xfer -> pc+=2, -> ALIGNED.
//               hold[1:0]==11: valid=fetch_valid_i, instr={w[15:0],hold};
//               xfer -> pop, hold<=w[31:16], pc+=4, stay HALF.
//    BR_HALF  : low halfword of first word discarded. w[17:16]!=11: valid=fetch_valid_i,
//               instr={16'h0,w[31:16]}; xfer -> pop, pc+=2, -> ALIGNED.
//               w[17:16]==11: valid=0, ready=fetch_valid_i; pop -> hold<=w[31:16], -> HALF.
//  - COMPRESSED=0: only IDLE/ALIGNED used, every word treated as 32-bit, compressed_o=0.
//  - pc arithmetic modulo 2^32 (wrap 0xFFFF_FFFE+2 -> 0). pc_o = pc in all non-IDLE states.
//  - Outputs stable while instr_valid_o && !id_ready_i and no branch (hold/pc/fifo head unchanged).
//  - Latency: fall-through, zero cycles from fetch_valid_i to instr_valid_o (except BR_HALF 32-bit:
//    +1 cycle). Compressed pair in one word: 2nd instr issued from hold without new fetch.
// STRUCTURE
//  - cv32e40p_pkg: typedef enum logic [1:0] {IDLE, ALIGNED, HALF, BR_HALF} realign_state_e.
//  - No sub-module; compressed-decode expansion stays in the downstream decoder.
//  - Assertions (CV32E40P_ASSERT_ON): branch_addr_i[0]==0; no fetch_ready_o on branch_i;
//    instr stable under back-pressure.
// TESTING
//  1 Reset, no branch, fetch_valid_i=1 -> instr_valid_o=0, fetch_ready_o=0 forever (IDLE).
//  2 Branch 0x100; words 0x00A00093, 0x00108113 -> two 32-bit instrs, pc 0x100,0x104, two pops.
//  3 Branch 0x200; word 0x45014501 -> c.li 0x4501 @0x200 (pop), 0x4501 @0x202 from hold, 1 pop.
//  4 Branch 0x300; words 0x00934501, 0x00000000 -> 0x4501 @0x300; straddler 0x00000093 @0x302.
//  5 Branch 0x402; word 0x00934501 -> discard pop, then with next word 0x12340000 emits
//    0x00000093 @0x402; hold=0x1234 then 16-bit 0x1234 @0x406.
//  6 id_ready_i=0 for 5 cycles mid-HALF straddle, then branch_i -> outputs stable, no pops;
//    branch cycle valid=0/ready=0; pc_o=target next cycle.

Source files
------------

// File: rtl/cv32e40p_instr_realigner_pkg.sv
// Shared types for the RV32IC instruction realigner.
package cv32e40p_instr_realigner_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALIGNED = 2'd1,
    HALF    = 2'd2,
    BR_HALF = 2'd3
  } realign_state_e;

  // A halfword whose two LSBs are both set starts a 32-bit instruction.
  function automatic logic is_32bit(input logic [15:0] hword);
    return (hword[1:0] == 2'b11);
  endfunction

endpackage

// File: rtl/cv32e40p_instr_realigner_sva.sv
// Protocol checker for the realigner: redirect address, pop/branch exclusion, back-pressure stability.
module cv32e40p_instr_realigner_sva (
  input logic        clk,
  input logic        rst_n,
  input logic        branch_i,
  input logic [31:0] branch_addr_i,
  input logic        fetch_ready_o,
  input logic        instr_valid_o,
  input logic [31:0] instr_rdata_o,
  input logic [31:0] pc_o,
  input logic        id_ready_i
);

  property p_branch_aligned;
    @(posedge clk) disable iff (!rst_n) branch_i |-> (branch_addr_i[0] == 1'b0);
  endproperty

  property p_no_pop_on_branch;
    @(posedge clk) disable iff (!rst_n) branch_i |-> !fetch_ready_o;
  endproperty

  property p_stable_backpressure;
    @(posedge clk) disable iff (!rst_n)
      (instr_valid_o && !id_ready_i && !branch_i) |=>
        (branch_i || (instr_valid_o && $stable(instr_rdata_o) && $stable(pc_o)));
  endproperty

  a_branch_aligned:      assert property (p_branch_aligned);
  a_no_pop_on_branch:    assert property (p_no_pop_on_branch);
  a_stable_backpressure: assert property (p_stable_backpressure);

endmodule

// File: rtl/cv32e40p_instr_realigner.sv
// Realigns 32-bit prefetch words into single RV32IC instructions for IF/ID, tracking their PC.
import cv32e40p_instr_realigner_pkg::*;

module cv32e40p_instr_realigner #(
  parameter int unsigned COMPRESSED = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  output logic        fetch_ready_o,
  output logic        instr_valid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_compressed_o,
  output logic [31:0] pc_o,
  input  logic        id_ready_i
);

  localparam bit RVC = (COMPRESSED != 0);

  realign_state_e state_r, state_n;
  logic [31:0]    pc_r, pc_n;
  logic [15:0]    hold_r, hold_n;
  logic           valid_s, ready_s;
  logic [31:0]    rdata_s;
  logic           xfer_s;

  assign xfer_s = fetch_valid_i && id_ready_i;

  // Next-state, output and datapath selection; a redirect overrides everything below it.
  always_comb begin
    valid_s = 1'b0;
    ready_s = 1'b0;
    rdata_s = 32'h0000_0000;
    state_n = state_r;
    pc_n    = pc_r;
    hold_n  = hold_r;
    case (state_r)
      IDLE: begin
        valid_s = 1'b0;
      end
      ALIGNED: begin
        valid_s = fetch_valid_i;
        if (!RVC || is_32bit(fetch_rdata_i[15:0])) begin
          rdata_s = fetch_rdata_i;
          if (xfer_s) begin
            ready_s = 1'b1;
            pc_n    = pc_r + 32'd4;
          end else begin
            ready_s = 1'b0;
          end
        end else begin
          rdata_s = {16'h0000, fetch_rdata_i[15:0]};
          if (xfer_s) begin
            ready_s = 1'b1;
            hold_n  = fetch_rdata_i[31:16];
            pc_n    = pc_r + 32'd2;
            state_n = HALF;
          end else begin
            ready_s = 1'b0;
          end
        end
      end
      HALF: begin
        if (!is_32bit(hold_r)) begin
          // Second compressed instruction of a word is issued without touching the fetch side.
          valid_s = 1'b1;
          rdata_s = {16'h0000, hold_r};
          if (id_ready_i) begin
            pc_n    = pc_r + 32'd2;
            state_n = ALIGNED;
          end else begin
            pc_n    = pc_r;
          end
        end else begin
          valid_s = fetch_valid_i;
          rdata_s = {fetch_rdata_i[15:0], hold_r};
          if (xfer_s) begin
            ready_s = 1'b1;
            hold_n  = fetch_rdata_i[31:16];
            pc_n    = pc_r + 32'd4;
          end else begin
            ready_s = 1'b0;
          end
        end
      end
      BR_HALF: begin
        if (!is_32bit(fetch_rdata_i[31:16])) begin
          valid_s = fetch_valid_i;
          rdata_s = {16'h0000, fetch_rdata_i[31:16]};
          if (xfer_s) begin
            ready_s = 1'b1;
            pc_n    = pc_r + 32'd2;
            state_n = ALIGNED;
          end else begin
            ready_s = 1'b0;
          end
        end else begin
          // Upper half starts a straddler: pop the word into hold and finish it from HALF.
          valid_s = 1'b0;
          ready_s = fetch_valid_i;
          if (fetch_valid_i) begin
            hold_n  = fetch_rdata_i[31:16];
            state_n = HALF;
          end else begin
            hold_n  = hold_r;
          end
        end
      end
      default: begin
        valid_s = 1'b0;
        ready_s = 1'b0;
        state_n = IDLE;
      end
    endcase
    if (branch_i) begin
      valid_s = 1'b0;
      ready_s = 1'b0;
      hold_n  = hold_r;
      pc_n    = branch_addr_i;
      state_n = (RVC && branch_addr_i[1]) ? BR_HALF : ALIGNED;
    end else begin
      pc_n    = pc_n;
    end
  end

  // State, PC and held upper halfword.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      pc_r    <= 32'h0000_0000;
      hold_r  <= 16'h0000;
    end else begin
      state_r <= state_n;
      pc_r    <= pc_n;
      hold_r  <= hold_n;
    end
  end

  assign fetch_ready_o      = ready_s;
  assign instr_valid_o      = valid_s;
  assign instr_rdata_o      = rdata_s;
  assign instr_compressed_o = RVC && valid_s && !is_32bit(rdata_s[15:0]);
  assign pc_o               = pc_r;

`ifdef CV32E40P_ASSERT_ON
  cv32e40p_instr_realigner_sva u_sva (
    .clk           (clk),
    .rst_n         (rst_n),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .fetch_ready_o (fetch_ready_o),
    .instr_valid_o (instr_valid_o),
    .instr_rdata_o (instr_rdata_o),
    .pc_o          (pc_o),
    .id_ready_i    (id_ready_i)
  );
`endif

endmodule

// File: tb/tb_cv32e40p_instr_realigner.sv
// Self-checking bench: memory-backed prefetch model plus a halfword-stream instruction reference.
module tb_cv32e40p_instr_realigner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch;
  logic [31:0] baddr;
  logic        fv;
  logic        idr;
  logic        fetch_ready;
  logic        instr_valid;
  logic [31:0] instr_rdata;
  logic        instr_compressed;
  logic [31:0] pc;
  logic [31:0] fetch_rdata;

  logic [15:0] mem [0:1023];
  logic [31:0] faddr;
  int          pops;
  logic [9:0]  widx;

  logic [31:0] q_instr [$];
  logic [31:0] q_pc [$];
  logic        q_c [$];
  bit          rnd_mode;
  logic        br_valid, br_ready;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  cv32e40p_instr_realigner #(.COMPRESSED(1)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .branch_i           (branch),
    .branch_addr_i      (baddr),
    .fetch_valid_i      (fv),
    .fetch_rdata_i      (fetch_rdata),
    .fetch_ready_o      (fetch_ready),
    .instr_valid_o      (instr_valid),
    .instr_rdata_o      (instr_rdata),
    .instr_compressed_o (instr_compressed),
    .pc_o               (pc),
    .id_ready_i         (idr)
  );

  // Prefetch buffer model: a sequential word stream from memory, restarted by each redirect.
  assign widx        = {faddr[10:2], 1'b0};
  assign fetch_rdata = {mem[widx | 10'd1], mem[widx]};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      faddr <= 32'h0;
      pops  <= 0;
    end else if (branch) begin
      faddr <= baddr & 32'hFFFF_FFFC;
    end else if (fv && fetch_ready) begin
      faddr <= faddr + 32'd4;
      pops  <= pops + 1;
    end
  end

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    return mem[a[10:1]];
  endfunction

  task automatic do_branch(input logic [31:0] addr);
    branch = 1'b1;
    baddr  = addr;
    fv     = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    idr    = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    br_valid = instr_valid;
    br_ready = fetch_ready;
    @(posedge clk); #1;
    branch = 1'b0;
    fv     = 1'b0;
  endtask

  // Collects up to n accepted instructions within a cycle budget; prefetch valid stays up until popped.
  task automatic consume(input int n, input int budget);
    bit popped;
    popped = 1'b1;
    q_instr.delete(); q_pc.delete(); q_c.delete();
    for (int c = 0; c < budget && q_instr.size() < n; c++) begin
      branch = 1'b0;
      if (rnd_mode) begin
        if (!(fv && !popped)) fv = ($urandom_range(0, 3) != 0);
        idr = ($urandom_range(0, 3) != 0);
      end else begin
        fv  = 1'b1;
        idr = 1'b1;
      end
      @(negedge clk);
      popped = fv && fetch_ready;
      if (instr_valid && idr) begin
        q_instr.push_back(instr_rdata);
        q_pc.push_back(pc);
        q_c.push_back(instr_compressed);
      end
      @(posedge clk); #1;
    end
    fv  = 1'b0;
    idr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; branch = 1'b0; baddr = 32'h0; fv = 1'b0; idr = 1'b0;
    #12;
    n_checks++;
    if ({instr_valid, fetch_ready, instr_compressed, instr_rdata, pc} !== 35'h0)
      $display("FAIL reset_outputs: got v=%b r=%b c=%b d=%h pc=%h expected all zero",
               instr_valid, fetch_ready, instr_compressed, instr_rdata, pc);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fv = 1'b1; idr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (instr_valid !== 1'b0 || fetch_ready !== 1'b0)
        $display("FAIL idle_quiet[%0d]: got valid=%b ready=%b expected 0/0", i, instr_valid, fetch_ready);
      else n_pass++;
      @(posedge clk); #1;
    end
    fv = 1'b0; idr = 1'b0;
  endtask

  task automatic test_aligned32();
    int p0;
    mem[10'h080] = 16'h0093; mem[10'h081] = 16'h00A0;
    mem[10'h082] = 16'h8113; mem[10'h083] = 16'h0010;
    do_branch(32'h100);
    p0 = pops;
    consume(2, 20);
    n_checks++;
    if (q_instr.size() != 2 || q_instr[0] !== 32'h00A00093 || q_pc[0] !== 32'h100 ||
        q_instr[1] !== 32'h00108113 || q_pc[1] !== 32'h104 || q_c[0] !== 1'b0 || q_c[1] !== 1'b0)
      $display("FAIL aligned32: got n=%0d %h@%h %h@%h expected 00a00093@100 00108113@104",
               q_instr.size(), q_instr[0], q_pc[0], q_instr[1], q_pc[1]);
    else n_pass++;
    n_checks++;
    if (pops - p0 !== 2) $display("FAIL aligned32_pops: got %0d expected 2", pops - p0);
    else n_pass++;
  endtask

  task automatic test_compressed_pair();
    int p0;
    mem[10'h100] = 16'h4501; mem[10'h101] = 16'h4501;
    do_branch(32'h200);
    p0 = pops;
    consume(2, 20);
    n_checks++;
    if (q_instr.size() != 2 || q_instr[0] !== 32'h4501 || q_pc[0] !== 32'h200 ||
        q_instr[1] !== 32'h4501 || q_pc[1] !== 32'h202 || q_c[0] !== 1'b1 || q_c[1] !== 1'b1)
      $display("FAIL cpair: got n=%0d %h@%h %h@%h expected 00004501@200 00004501@202",
               q_instr.size(), q_instr[0], q_pc[0], q_instr[1], q_pc[1]);
    else n_pass++;
    n_checks++;
    if (pops - p0 !== 1) $display("FAIL cpair_pops: got %0d expected 1", pops - p0);
    else n_pass++;
  endtask

  task automatic test_straddle();
    int p0;
    mem[10'h180] = 16'h4501; mem[10'h181] = 16'h0093;
    mem[10'h182] = 16'h0000; mem[10'h183] = 16'h0000;
    do_branch(32'h300);
    p0 = pops;
    consume(2, 20);
    n_checks++;
    if (q_instr.size() != 2 || q_instr[0] !== 32'h4501 || q_pc[0] !== 32'h300 ||
        q_instr[1] !== 32'h00000093 || q_pc[1] !== 32'h302 || q_c[0] !== 1'b1 || q_c[1] !== 1'b0)
      $display("FAIL straddle: got n=%0d %h@%h %h@%h expected 00004501@300 00000093@302",
               q_instr.size(), q_instr[0], q_pc[0], q_instr[1], q_pc[1]);
    else n_pass++;
    n_checks++;
    if (pops - p0 !== 2) $display("FAIL straddle_pops: got %0d expected 2", pops - p0);
    else n_pass++;
  endtask

  task automatic test_branch_half();
    int p0;
    mem[10'h200] = 16'h4501; mem[10'h201] = 16'h0093;
    mem[10'h202] = 16'h0000; mem[10'h203] = 16'h1234;
    do_branch(32'h402);
    p0 = pops;
    consume(2, 20);
    n_checks++;
    if (q_instr.size() != 2 || q_instr[0] !== 32'h00000093 || q_pc[0] !== 32'h402 ||
        q_instr[1] !== 32'h1234 || q_pc[1] !== 32'h406 || q_c[0] !== 1'b0 || q_c[1] !== 1'b1)
      $display("FAIL br_half: got n=%0d %h@%h %h@%h expected 00000093@402 00001234@406",
               q_instr.size(), q_instr[0], q_pc[0], q_instr[1], q_pc[1]);
    else n_pass++;
    n_checks++;
    if (pops - p0 !== 2) $display("FAIL br_half_pops: got %0d expected 2", pops - p0);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int p0;
    mem[10'h280] = 16'h4501; mem[10'h281] = 16'h0093;
    mem[10'h282] = 16'h0000; mem[10'h283] = 16'h0000;
    do_branch(32'h500);
    consume(1, 10);
    p0 = pops;
    fv = 1'b1; idr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (instr_valid !== 1'b1 || instr_rdata !== 32'h00000093 || pc !== 32'h502 || fetch_ready !== 1'b0)
        $display("FAIL bp_hold[%0d]: got v=%b d=%h pc=%h r=%b expected 1 00000093 00000502 0",
                 i, instr_valid, instr_rdata, pc, fetch_ready);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (pops !== p0) $display("FAIL bp_pops: got %0d expected %0d", pops, p0);
    else n_pass++;
    branch = 1'b1; baddr = 32'h600;
    @(negedge clk);
    n_checks++;
    if (instr_valid !== 1'b0 || fetch_ready !== 1'b0)
      $display("FAIL bp_branch_cycle: got valid=%b ready=%b expected 0/0", instr_valid, fetch_ready);
    else n_pass++;
    @(posedge clk); #1;
    branch = 1'b0; fv = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pc !== 32'h600) $display("FAIL bp_new_pc: got %h expected 00000600", pc);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  // Random programs and redirects checked against a sequential halfword-stream decode.
  task automatic test_random();
    logic [31:0] tgt, mpc, exp_i;
    logic [15:0] hw;
    int n;
    for (int i = 0; i < 1024; i++) begin
      hw = 16'($urandom);
      if ($urandom_range(0, 1) == 1) hw[1:0] = 2'b11;
      mem[i] = hw;
    end
    rnd_mode = 1'b1;
    for (int s = 0; s < 16; s++) begin
      tgt = (s >= 13) ? (32'hFFFF_FFF8 + 32'(2 * (s - 13))) : (32'($urandom_range(0, 1023)) << 1);
      n = $urandom_range(4, 20);
      do_branch(tgt);
      n_checks++;
      if (br_valid !== 1'b0 || br_ready !== 1'b0)
        $display("FAIL rnd_branch[%0d]: got valid=%b ready=%b expected 0/0", s, br_valid, br_ready);
      else n_pass++;
      consume(n, 12 * n + 20);
      n_checks++;
      if (q_instr.size() != n)
        $display("FAIL rnd_count[%0d]: got %0d expected %0d", s, q_instr.size(), n);
      else n_pass++;
      mpc = tgt;
      for (int k = 0; k < q_instr.size(); k++) begin
        hw = hw_at(mpc);
        exp_i = (hw[1:0] == 2'b11) ? {hw_at(mpc + 32'd2), hw} : {16'h0000, hw};
        n_checks++;
        if (q_instr[k] !== exp_i || q_pc[k] !== mpc || q_c[k] !== (hw[1:0] != 2'b11))
          $display("FAIL rnd_instr[%0d.%0d]: got %h@%h c=%b expected %h@%h c=%b",
                   s, k, q_instr[k], q_pc[k], q_c[k], exp_i, mpc, (hw[1:0] != 2'b11));
        else n_pass++;
        mpc = mpc + ((hw[1:0] == 2'b11) ? 32'd4 : 32'd2);
      end
    end
    rnd_mode = 1'b0;
  endtask

  initial begin
    rnd_mode = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    test_reset();
    test_aligned32();
    test_compressed_pair();
    test_straddle();
    test_branch_half();
    test_backpressure();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
